uart_param_core: RTL

- Parametrised successor to the fixed 32-bit UART top: baud tick generator, transmitter and receiver in one block.
- Generalised in data width, baud divisor, oversampling ratio, parity mode and stop-bit count.
- Adds a valid/ready TX handshake, an oversampled RX with mid-bit sampling and false-start rejection, and a one-cycle RX valid strobe.
- Sits between the system bus and the serial pins.

---
 rtl/uart_param_core.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_param_core.sv
// uart_param_core: parametrised UART with baud tick generator, transmitter and oversampled receiver.
// Latency: Tx_out falls one cycle after Tx_valid&Tx_ready; Rx_valid pulses one cycle at mid final stop bit.
// Backpressure: Tx_ready is low while a TX frame is in flight; RX has none, an unread word is overwritten.
// Build option: define UART_LOOPBACK_EN to feed the receiver from Tx_out instead of Rx_in.
module uart_param_core #(
  parameter int DATA_WIDTH  = 32,
  parameter int CLK_DIV     = 16,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1
) (
  input  logic                  Clock_In,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] Tx_data,
  input  logic                  Tx_valid,
  output logic                  Tx_ready,
  output logic                  Tx_out,
  input  logic                  Rx_in,
  output logic [DATA_WIDTH-1:0] Rx_data,
  output logic                  Rx_valid,
  output logic                  Parity_Error,
  output logic                  Stop_Error,
  output logic                  Tx_busy,
  output logic                  Rx_busy
);

  localparam int DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PhW  = $clog2(OVERSAMPLE);
  localparam int BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [PhW-1:0]  PhLast  = PhW'(OVERSAMPLE - 1);
  localparam logic [PhW-1:0]  PhHalf  = PhW'(OVERSAMPLE / 2 - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_WIDTH - 1);
  localparam logic            StopLast = (STOP_BITS == 2);
  localparam logic            ParOdd   = (PARITY_MODE == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  logic [DivW-1:0]       div_q;
  logic                  tick;
  state_e                tx_st_q;
  logic [PhW-1:0]        tx_ph_q;
  logic [BitW-1:0]       tx_bit_q;
  logic                  tx_stop_q;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic                  tx_par_q, tx_out_q, tx_ready_q, tx_busy_q;
  logic                  rx_src, rx_meta_q, rx_sync_q;
  state_e                rx_st_q;
  logic [PhW-1:0]        rx_ph_q;
  logic [BitW-1:0]       rx_bit_q;
  logic                  rx_stop_q;
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d, rx_data_q;
  logic                  rx_perr_q, rx_serr_q, rx_vld_q, perr_q, serr_q, rx_busy_q;

  assign tick    = (div_q == DivLast);
  assign tx_sh_d = tx_sh_q >> 1;

  // Free-running oversample tick: one-cycle pulse every CLK_DIV clocks.
  always_ff @(posedge Clock_In or negedge Reset) begin
    if (!Reset)    div_q <= '0;
    else if (tick) div_q <= '0;
    else           div_q <= div_q + DivW'(1);
  end

  // TX FSM: latch word on handshake, then shift start/data/parity/stop, one bit per OVERSAMPLE ticks.
  always_ff @(posedge Clock_In or negedge Reset) begin
    if (!Reset) begin
      tx_st_q    <= S_IDLE;
      tx_ph_q    <= '0;
      tx_bit_q   <= '0;
      tx_stop_q  <= 1'b0;
      tx_sh_q    <= '0;
      tx_par_q   <= 1'b0;
      tx_out_q   <= 1'b1;
      tx_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else if (tx_st_q == S_IDLE) begin
      if (Tx_valid && tx_ready_q) begin
        tx_sh_q    <= Tx_data;
        tx_par_q   <= (^Tx_data) ^ ParOdd;
        tx_st_q    <= S_START;
        tx_ph_q    <= '0;
        tx_out_q   <= 1'b0;
        tx_ready_q <= 1'b0;
        tx_busy_q  <= 1'b1;
      end
    end else if (tick) begin
      if (tx_ph_q != PhLast) begin
        tx_ph_q <= tx_ph_q + PhW'(1);
      end else begin
        tx_ph_q <= '0;
        case (tx_st_q)
          S_START: begin
            tx_st_q  <= S_DATA;
            tx_bit_q <= '0;
            tx_out_q <= tx_sh_q[0];
          end
          S_DATA: begin
            tx_sh_q <= tx_sh_d;
            if (tx_bit_q == BitLast) begin
              if (PARITY_MODE != 0) begin
                tx_st_q  <= S_PARITY;
                tx_out_q <= tx_par_q;
              end else begin
                tx_st_q   <= S_STOP;
                tx_stop_q <= 1'b0;
                tx_out_q  <= 1'b1;
              end
            end else begin
              tx_bit_q <= tx_bit_q + BitW'(1);
              tx_out_q <= tx_sh_d[0];
            end
          end
          S_PARITY: begin
            tx_st_q   <= S_STOP;
            tx_stop_q <= 1'b0;
            tx_out_q  <= 1'b1;
          end
          S_STOP: begin
            if (tx_stop_q == StopLast) begin
              tx_st_q    <= S_IDLE;
              tx_ready_q <= 1'b1;
              tx_busy_q  <= 1'b0;
            end else begin
              tx_stop_q <= 1'b1;
            end
          end
          default: tx_st_q <= S_IDLE;
        endcase
      end
    end
  end

`ifdef UART_LOOPBACK_EN
  assign rx_src = tx_out_q;
`else
  assign rx_src = Rx_in;
`endif

  // Two-flop synchroniser on the asynchronous serial input; idles high.
  always_ff @(posedge Clock_In or negedge Reset) begin
    if (!Reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_src;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Incoming bit lands in the MSB; after DATA_WIDTH shifts the first bit sits in the LSB.
  always_comb begin
    rx_sh_d                 = rx_sh_q >> 1;
    rx_sh_d[DATA_WIDTH-1]   = rx_sync_q;
  end

  // RX FSM: half-bit start check rejects glitches, then mid-bit samples; publish at last stop sample.
  always_ff @(posedge Clock_In or negedge Reset) begin
    if (!Reset) begin
      rx_st_q   <= S_IDLE;
      rx_ph_q   <= '0;
      rx_bit_q  <= '0;
      rx_stop_q <= 1'b0;
      rx_sh_q   <= '0;
      rx_perr_q <= 1'b0;
      rx_serr_q <= 1'b0;
      rx_data_q <= '0;
      rx_vld_q  <= 1'b0;
      perr_q    <= 1'b0;
      serr_q    <= 1'b0;
      rx_busy_q <= 1'b0;
    end else begin
      rx_vld_q <= 1'b0;
      case (rx_st_q)
        S_IDLE: begin
          if (!rx_sync_q) begin
            rx_st_q   <= S_START;
            rx_ph_q   <= '0;
            rx_busy_q <= 1'b1;
          end
        end
        S_START: begin
          if (tick) begin
            if (rx_ph_q != PhHalf) begin
              rx_ph_q <= rx_ph_q + PhW'(1);
            end else begin
              rx_ph_q <= '0;
              if (rx_sync_q) begin
                rx_st_q   <= S_IDLE;
                rx_busy_q <= 1'b0;
              end else begin
                rx_st_q   <= S_DATA;
                rx_bit_q  <= '0;
                rx_perr_q <= 1'b0;
                rx_serr_q <= 1'b0;
              end
            end
          end
        end
        default: begin
          if (tick) begin
            if (rx_ph_q != PhLast) begin
              rx_ph_q <= rx_ph_q + PhW'(1);
            end else begin
              rx_ph_q <= '0;
              if (rx_st_q == S_DATA) begin
                rx_sh_q <= rx_sh_d;
                if (rx_bit_q == BitLast) begin
                  rx_stop_q <= 1'b0;
                  rx_st_q   <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                end else begin
                  rx_bit_q <= rx_bit_q + BitW'(1);
                end
              end else if (rx_st_q == S_PARITY) begin
                rx_perr_q <= rx_sync_q ^ (^rx_sh_q) ^ ParOdd;
                rx_st_q   <= S_STOP;
              end else if (rx_stop_q == StopLast) begin
                rx_data_q <= rx_sh_q;
                perr_q    <= rx_perr_q;
                serr_q    <= rx_serr_q | ~rx_sync_q;
                rx_vld_q  <= 1'b1;
                rx_st_q   <= S_IDLE;
                rx_busy_q <= 1'b0;
              end else begin
                rx_serr_q <= rx_serr_q | ~rx_sync_q;
                rx_stop_q <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  assign Tx_out       = tx_out_q;
  assign Tx_ready     = tx_ready_q;
  assign Tx_busy      = tx_busy_q;
  assign Rx_data      = rx_data_q;
  assign Rx_valid     = rx_vld_q;
  assign Parity_Error = perr_q;
  assign Stop_Error   = serr_q;
  assign Rx_busy      = rx_busy_q;

endmodule
